design_36_result_fifo: RTL and testbench



---
 rtl/design_36_result_fifo_if.sv | 36 +++
 rtl/design_36_result_fifo.sv | 106 ++++++++++
 tb/tb_design_36_result_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/design_36_result_fifo_if.sv
// Result buffer bus: producer strobe, consumer valid/ready handshake, status and sum.
// Ports (signals):
//   in_valid/in_data      producer result strobe and value
//   out_valid/out_ready   head-entry handshake; out_data is the head value
//   count/full/empty      occupancy status
//   overflow              sticky drop flag
//   sum_clr/sum           running-sum clear and value (sum is 0 when not built)
// Modports: slave = buffer side, master = producer/consumer side.
interface design_36_result_fifo_if #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          sum_clr;
  logic [W+7:0]  sum;

  modport slave (
    input  in_valid, in_data, out_ready, sum_clr,
    output out_valid, out_data, count, full, empty, overflow, sum
  );

  modport master (
    output in_valid, in_data, out_ready, sum_clr,
    input  out_valid, out_data, count, full, empty, overflow, sum
  );
endinterface

// File: rtl/design_36_result_fifo.sv
// Output buffer for the design_36 datapath: captures each valid result into a
// circular FIFO and presents it first-word fall-through over valid/ready.
// The producer cannot be stalled, so results arriving while full (and with no
// pop that edge) are dropped and flagged in a sticky overflow bit.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset; clears storage, pointers and flags
//   bus    design_36_result_fifo_if.slave (see interface header)
// Optional feature macro: DESIGN_36_RESULT_FIFO_SUM_EN builds a running sum of
// popped results; otherwise sum is tied to 0 and sum_clr is ignored.
module design_36_result_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  design_36_result_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = W + 8;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic full_c, empty_c, push_c, pop_c;

  // Status decodes of the occupancy counter.
  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == CW'(0));

  // A pop frees a slot in the same edge, so a full buffer still accepts then.
  assign pop_c  = !empty_c && bus.out_ready;
  assign push_c = bus.in_valid && (!full_c || pop_c);

  // Pointer, count and sticky-overflow next state.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_c) wp_d = wp_q + AW'(1);
    if (pop_c)  rp_d = rp_q + AW'(1);
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !push_c) count_d = count_q - CW'(1);
    if (bus.in_valid && full_c && !pop_c) overflow_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage; reset to zero so out_data reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wp_q] <= bus.in_data;
    end
  end

  assign bus.out_data  = mem_q[rp_q];
  assign bus.out_valid = !empty_c;
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.overflow  = overflow_q;

`ifdef DESIGN_36_RESULT_FIFO_SUM_EN
  logic [SW-1:0] sum_q, sum_d;

  // Clear wins over accumulation, but a coincident pop still lands its value.
  always_comb begin
    sum_d = sum_q;
    if (bus.sum_clr) sum_d = pop_c ? SW'(bus.out_data) : '0;
    else if (pop_c)  sum_d = sum_q + SW'(bus.out_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign bus.sum = sum_q;
`else
  logic sum_clr_unused;
  assign sum_clr_unused = bus.sum_clr;
  assign bus.sum        = SW'(0);
`endif

endmodule

// File: tb/tb_design_36_result_fifo.sv
// Directed, table-driven bench for design_36_result_fifo plus hand-written
// sequences for streaming, asynchronous reset and the running sum.
module tb_design_36_result_fifo;

  localparam int unsigned W     = 10;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  design_36_result_fifo_if #(.W(W), .DEPTH(DEPTH)) bus ();

  design_36_result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       in_valid;
    logic [9:0] in_data;
    logic       out_ready;
    logic       exp_valid;
    logic [9:0] exp_data;
    logic       chk_data;
    int         exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [9:0] d, input logic rdy,
                     input logic ev, input logic [9:0] ed, input logic cd,
                     input int ec, input logic ef, input logic eo);
    vec_t v;
    v.rst = r; v.in_valid = iv; v.in_data = d; v.out_ready = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.chk_data = cd;
    v.exp_count = ec; v.exp_full = ef; v.exp_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic chk_status(input string tag, input logic ev, input int ec,
                            input logic ef, input logic eo);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".count"},     32'(bus.count), 32'(ec));
    chk({tag, ".full"},      32'(bus.full), 32'(ef));
    chk({tag, ".empty"},     32'(bus.empty), 32'(ec == 0));
    chk({tag, ".overflow"},  32'(bus.overflow), 32'(eo));
  endtask

  task automatic cyc(input logic iv, input logic [9:0] d, input logic rdy, input logic clr);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.sum_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 10'h0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.sum_clr   = 1'b0;

    // Reset state and single push latency.
    add(1, 0, 10'h000, 0, 0, 10'h000, 1, 0, 0, 0);
    add(0, 1, 10'h155, 0, 1, 10'h155, 1, 1, 0, 0);
    add(0, 0, 10'h000, 1, 0, 10'h000, 0, 0, 0, 0);
    // Ready while empty must not underflow.
    add(0, 0, 10'h000, 1, 0, 10'h000, 0, 0, 0, 0);
    // Fill, drop 0x005, drain 1..4.
    add(0, 1, 10'h001, 0, 1, 10'h001, 1, 1, 0, 0);
    add(0, 1, 10'h002, 0, 1, 10'h001, 1, 2, 0, 0);
    add(0, 1, 10'h003, 0, 1, 10'h001, 1, 3, 0, 0);
    add(0, 1, 10'h004, 0, 1, 10'h001, 1, 4, 1, 0);
    add(0, 1, 10'h005, 0, 1, 10'h001, 1, 4, 1, 1);
    add(0, 0, 10'h000, 1, 1, 10'h002, 1, 3, 0, 1);
    add(0, 0, 10'h000, 1, 1, 10'h003, 1, 2, 0, 1);
    add(0, 0, 10'h000, 1, 1, 10'h004, 1, 1, 0, 1);
    add(0, 0, 10'h000, 1, 0, 10'h000, 0, 0, 0, 1);
    // Reset clears overflow; full with simultaneous push and pop.
    add(1, 0, 10'h000, 0, 0, 10'h000, 1, 0, 0, 0);
    add(0, 1, 10'h001, 0, 1, 10'h001, 1, 1, 0, 0);
    add(0, 1, 10'h002, 0, 1, 10'h001, 1, 2, 0, 0);
    add(0, 1, 10'h003, 0, 1, 10'h001, 1, 3, 0, 0);
    add(0, 1, 10'h004, 0, 1, 10'h001, 1, 4, 1, 0);
    add(0, 1, 10'h3FF, 1, 1, 10'h002, 1, 4, 1, 0);
    add(0, 0, 10'h000, 1, 1, 10'h003, 1, 3, 0, 0);
    add(0, 0, 10'h000, 1, 1, 10'h004, 1, 2, 0, 0);
    add(0, 0, 10'h000, 1, 1, 10'h3FF, 1, 1, 0, 0);
    add(0, 0, 10'h000, 1, 0, 10'h000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      cyc(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, 1'b0);
      chk_status($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_count,
                 vecs[i].exp_full, vecs[i].exp_ovf);
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d.out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
      rst = 1'b0;
    end

    // Streaming push+pop: head tracks the latest value, count stays at 1.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 10'(i), 1'b1, 1'b0);
      chk($sformatf("stream%0d.out_data", i), 32'(bus.out_data), 32'(i));
      chk($sformatf("stream%0d.count", i), 32'(bus.count), 32'd1);
    end
    cyc(1'b0, 10'h0, 1'b1, 1'b0);
    chk_status("stream_end", 1'b0, 0, 1'b0, 1'b0);

    // Asynchronous reset away from any clock edge with 3 entries stored.
    cyc(1'b1, 10'h011, 1'b0, 1'b0);
    cyc(1'b1, 10'h022, 1'b0, 1'b0);
    cyc(1'b1, 10'h033, 1'b0, 1'b0);
    chk("pre_rst.count", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_status("async_rst", 1'b0, 0, 1'b0, 1'b0);
    chk("async_rst.out_data", 32'(bus.out_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 10'h0AA, 1'b0, 1'b0);
    chk_status("post_rst", 1'b1, 1, 1'b0, 1'b0);
    chk("post_rst.out_data", 32'(bus.out_data), 32'h0AA);

    // Running sum.
    do_reset();
    chk("sum.reset", 32'(bus.sum), 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 10'h3FF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 10'h0, 1'b1, 1'b0);
`ifdef DESIGN_36_RESULT_FIFO_SUM_EN
      chk($sformatf("sum.acc%0d", i), 32'(bus.sum), 32'h3FF * 32'(i + 1));
`else
      chk($sformatf("sum.acc%0d", i), 32'(bus.sum), 32'h0);
`endif
    end
    cyc(1'b1, 10'h010, 1'b0, 1'b0);
    cyc(1'b0, 10'h0, 1'b1, 1'b1);
`ifdef DESIGN_36_RESULT_FIFO_SUM_EN
    chk("sum.clr_pop", 32'(bus.sum), 32'h010);
`else
    chk("sum.clr_pop", 32'(bus.sum), 32'h0);
`endif
    cyc(1'b0, 10'h0, 1'b0, 1'b1);
    chk("sum.clr", 32'(bus.sum), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
